// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Opcodes, funct codes, ALU codes, ALUOp codes and FSM states.
package mc_control_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU decoder: maps ALUOp and funct to an ALU operation code.
// funct_ok reports whether funct is a supported R-type operation.
module alu_decoder
   import mc_control_unit_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_sel,
   output logic       funct_ok
);

   logic [2:0] fn_sel;

   // Decode funct into an ALU code and legality flag.
   always_comb begin
      fn_sel   = ALU_ADD;
      funct_ok = 1'b0;
      case (funct)
         FN_ADD: begin fn_sel = ALU_ADD; funct_ok = 1'b1; end
         FN_SUB: begin fn_sel = ALU_SUB; funct_ok = 1'b1; end
         FN_AND: begin fn_sel = ALU_AND; funct_ok = 1'b1; end
         FN_OR:  begin fn_sel = ALU_OR;  funct_ok = 1'b1; end
         FN_SLT: begin fn_sel = ALU_SLT; funct_ok = 1'b1; end
         default: ;
      endcase
   end

   // Select the final ALU operation from the ALUOp class.
   always_comb begin
      alu_sel = 3'b000;
      case (alu_op)
         ALUOP_ADD:   alu_sel = ALU_ADD;
         ALUOP_SUB:   alu_sel = ALU_SUB;
         ALUOP_FUNCT: alu_sel = fn_sel;
         default:     alu_sel = 3'b000;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM with memory wait states,
// ADDI/J support and illegal-instruction detection.
module mc_control_unit
   import mc_control_unit_pkg::*;
#(
   parameter int ALU_SEL_W    = 3,
   parameter bit SUPPORT_ADDI = 1'b1,
   parameter bit SUPPORT_J    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [5:0]           Opcode,
   input  logic [5:0]           Funct,
   input  logic                 Zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 IorD,
   output logic                 DM_WRITE_ENABLE,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 Branch,
   output logic                 PCEn,
   output logic [1:0]           PCSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [ALU_SEL_W-1:0] ALUsel,
   output logic                 RF_WRITE_ENABLE,
   output logic                 RFDSel,
   output logic                 MtoRFSEL,
   output logic                 instr_done,
   output logic                 illegal
);

   state_t     state_q;
   state_t     state_d;
   logic       is_sw_q;
   logic [5:0] funct_q;

   logic [5:0] dec_funct;
   logic [2:0] dec_sel;
   logic       funct_ok;
   alu_op_t    alu_op;
   logic       alu_en;

   logic       op_mem;
   logic       op_r;
   logic       op_beq;
   logic       op_addi;
   logic       op_j;

   logic       mem_req_c;
   logic       iord_c;
   logic       dmwe_c;
   logic       irw_c;
   logic       pcw_c;
   logic       br_c;
   logic [1:0] pcsrc_c;
   logic       srca_c;
   logic [1:0] srcb_c;
   logic       rfwe_c;
   logic       rfd_c;
   logic       m2r_c;
   logic       done_c;
   logic       ill_c;
   logic [2:0] alu_sel_c;

   // The live funct is only consulted in DECODE; later the latched copy drives the ALU.
   assign dec_funct = (state_q == S_DECODE) ? Funct : funct_q;

   alu_decoder u_alu_dec (
      .alu_op   (alu_op),
      .funct    (dec_funct),
      .alu_sel  (dec_sel),
      .funct_ok (funct_ok)
   );

   assign op_mem  = (Opcode == OP_LW) || (Opcode == OP_SW);
   assign op_r    = (Opcode == OP_RTYPE) && funct_ok;
   assign op_beq  = (Opcode == OP_BEQ);
   assign op_addi = SUPPORT_ADDI && (Opcode == OP_ADDI);
   assign op_j    = SUPPORT_J && (Opcode == OP_J);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Capture instruction fields in DECODE so later IR changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_sw_q <= 1'b0;
         funct_q <= 6'b0;
      end else if (state_q == S_DECODE) begin
         is_sw_q <= (Opcode == OP_SW);
         funct_q <= Funct;
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      state_d   = S_FETCH;
      mem_req_c = 1'b0;
      iord_c    = 1'b0;
      dmwe_c    = 1'b0;
      irw_c     = 1'b0;
      pcw_c     = 1'b0;
      br_c      = 1'b0;
      pcsrc_c   = 2'b00;
      srca_c    = 1'b0;
      srcb_c    = 2'b00;
      rfwe_c    = 1'b0;
      rfd_c     = 1'b0;
      m2r_c     = 1'b0;
      done_c    = 1'b0;
      ill_c     = 1'b0;
      alu_op    = ALUOP_ADD;
      alu_en    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            srcb_c    = 2'b01;
            alu_en    = 1'b1;
            irw_c     = mem_ready;
            pcw_c     = mem_ready;
            state_d   = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            srcb_c = 2'b11;
            alu_en = 1'b1;
            unique case (1'b1)
               op_mem:  state_d = S_MEMADR;
               op_r:    state_d = S_EXECUTE;
               op_beq:  state_d = S_BRANCH;
               op_addi: state_d = S_ADDIEX;
               op_j:    state_d = S_JUMP;
               default: begin
                  ill_c   = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            srca_c  = 1'b1;
            srcb_c  = 2'b10;
            alu_en  = 1'b1;
            state_d = is_sw_q ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            state_d   = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            rfwe_c = 1'b1;
            m2r_c  = 1'b1;
            done_c = 1'b1;
         end
         S_MEMWR: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            dmwe_c    = mem_ready;
            done_c    = mem_ready;
            state_d   = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            srca_c  = 1'b1;
            alu_op  = ALUOP_FUNCT;
            alu_en  = 1'b1;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            rfwe_c = 1'b1;
            rfd_c  = 1'b1;
            done_c = 1'b1;
         end
         S_BRANCH: begin
            srca_c  = 1'b1;
            alu_op  = ALUOP_SUB;
            alu_en  = 1'b1;
            br_c    = 1'b1;
            pcsrc_c = 2'b01;
            done_c  = 1'b1;
         end
         S_ADDIEX: begin
            srca_c  = 1'b1;
            srcb_c  = 2'b10;
            alu_en  = 1'b1;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            rfwe_c = 1'b1;
            done_c = 1'b1;
         end
         S_JUMP: begin
            pcw_c   = 1'b1;
            pcsrc_c = 2'b10;
            done_c  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign alu_sel_c = alu_en ? dec_sel : 3'b000;

   // Every output is held low while reset is asserted.
   assign mem_req         = rst_n & mem_req_c;
   assign IorD            = rst_n & iord_c;
   assign DM_WRITE_ENABLE = rst_n & dmwe_c;
   assign IRWrite         = rst_n & irw_c;
   assign PCWrite         = rst_n & pcw_c;
   assign Branch          = rst_n & br_c;
   assign PCEn            = PCWrite | (Branch & Zero);
   assign PCSrc           = pcsrc_c & {2{rst_n}};
   assign ALUSrcA         = rst_n & srca_c;
   assign ALUSrcB         = srcb_c & {2{rst_n}};
   assign ALUsel          = ALU_SEL_W'(alu_sel_c) & {ALU_SEL_W{rst_n}};
   assign RF_WRITE_ENABLE = rst_n & rfwe_c;
   assign RFDSel          = rst_n & rfd_c;
   assign MtoRFSEL        = rst_n & m2r_c;
   assign instr_done      = rst_n & done_c;
   assign illegal         = rst_n & ill_c;

endmodule
